issue_queue: RTL and testbench

- Parametrised N-entry out-of-order issue queue; successor to the single-slot issue buffer.
- Accepts one dispatched micro-op per cycle and tracks source readiness via NWB tagged wakeup ports.
- Clears or kills entries on branch resolution and issues the oldest ready entry to one functional unit through a valid/ready handshake.
- Sits between rename/dispatch and the register-read stage.

---
 rtl/issue_queue_pkg.sv | 52 +++++
 rtl/issue_queue_if.sv | 41 ++++
 rtl/iq_slot.sv | 87 ++++++++
 rtl/issue_queue.sv | 114 +++++++++++
 tb/tb_issue_queue.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: payload field layout and the
// write-back port slicing helper used by every queue that snoops wakeups.
package issue_queue_pkg;

  localparam int UOP_W        = 7;
  localparam int WB_FLAT_MAX  = 256;
  localparam int WB_SLICE_MAX = 32;

  localparam int DEF_WIDTH_REG = 5;
  localparam int DEF_WIDTH_TAG = 5;
  localparam int DEF_WIDTH_BRM = 3;

  // Payload layout, LSB first: RS1, RS2, RDst, tag, BrMask, UOPCode
  function automatic int pay_width(input int w_reg, input int w_tag, input int w_brm);
    return UOP_W + w_brm + w_tag + 3 * w_reg;
  endfunction

  function automatic int off_rs1(input int w_reg);
    return 0 * w_reg;
  endfunction

  function automatic int off_rs2(input int w_reg);
    return w_reg;
  endfunction

  function automatic int off_rdst(input int w_reg);
    return 2 * w_reg;
  endfunction

  function automatic int off_tag(input int w_reg);
    return 3 * w_reg;
  endfunction

  function automatic int off_brm(input int w_reg, input int w_tag);
    return 3 * w_reg + w_tag;
  endfunction

  function automatic int off_uop(input int w_reg, input int w_tag, input int w_brm);
    return 3 * w_reg + w_tag + w_brm;
  endfunction

  localparam int WIDTH_PAY = pay_width(DEF_WIDTH_REG, DEF_WIDTH_TAG, DEF_WIDTH_BRM);

  // Port k of a flattened wakeup bus sits at bits [(k+1)*w-1 : k*w]
  function automatic logic [WB_SLICE_MAX-1:0] wb_slice(input logic [WB_FLAT_MAX-1:0] flat,
                                                       input int k, input int w);
    logic [WB_FLAT_MAX-1:0] shifted;
    shifted = flat >> (k * w);
    return shifted[WB_SLICE_MAX-1:0] & ((WB_SLICE_MAX'(1) << w) - WB_SLICE_MAX'(1));
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, wakeup, branch-resolution and issue signals of the issue queue.
interface issue_queue_if #(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int DEPTH     = 8,
  parameter int NWB       = 4
);
  import issue_queue_pkg::*;

  localparam int WIDTH_PAY = pay_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM);
  localparam int WIDTH_CNT = $clog2(DEPTH + 1);

  logic                     i_flush;
  logic                     i_dis_val;
  logic [WIDTH_PAY-1:0]     i_dis_data;
  logic                     i_dis_p1;
  logic                     i_dis_p2;
  logic                     o_dis_rdy;
  logic [NWB-1:0]           i_wb_val;
  logic [NWB*WIDTH_REG-1:0] i_wb_dst;
  logic [WIDTH_BRM-1:0]     i_br_kill;
  logic [WIDTH_BRM-1:0]     i_br_clr;
  logic                     o_iss_val;
  logic [WIDTH_PAY-1:0]     o_iss_data;
  logic                     i_iss_rdy;
  logic [WIDTH_CNT-1:0]     o_count;

  modport master (
    output i_flush, i_dis_val, i_dis_data, i_dis_p1, i_dis_p2,
           i_wb_val, i_wb_dst, i_br_kill, i_br_clr, i_iss_rdy,
    input  o_dis_rdy, o_iss_val, o_iss_data, o_count
  );

  modport slave (
    input  i_flush, i_dis_val, i_dis_data, i_dis_p1, i_dis_p2,
           i_wb_val, i_wb_dst, i_br_kill, i_br_clr, i_iss_rdy,
    output o_dis_rdy, o_iss_val, o_iss_data, o_count
  );

endinterface

// File: rtl/iq_slot.sv
// One issue-queue entry: payload, source-ready bits, wakeup compare,
// branch kill/clear and the per-entry issue request.
module iq_slot
  import issue_queue_pkg::*;
#(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int NWB       = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            flush,
  input  logic [WIDTH_BRM-1:0]                            br_kill,
  input  logic [WIDTH_BRM-1:0]                            br_clr,
  input  logic [NWB-1:0]                                  wb_val,
  input  logic [NWB*WIDTH_REG-1:0]                        wb_dst,
  input  logic                                            wr_en,
  input  logic [pay_width(WIDTH_REG,WIDTH_TAG,WIDTH_BRM)-1:0] wr_data,
  input  logic                                            wr_p1,
  input  logic                                            wr_p2,
  input  logic                                            iss_en,
  output logic                                            valid,
  output logic                                            valid_next,
  output logic                                            req,
  output logic                                            killed,
  output logic [pay_width(WIDTH_REG,WIDTH_TAG,WIDTH_BRM)-1:0] payload
);

  localparam int WP     = pay_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM);
  localparam int RS1_LO = off_rs1(WIDTH_REG);
  localparam int RS2_LO = off_rs2(WIDTH_REG);
  localparam int BRM_LO = off_brm(WIDTH_REG, WIDTH_TAG);

  logic          p1, p2;
  logic          hit1, hit2, kill_hit;
  logic [WP-1:0] src, new_pay;

  // A dispatching entry compares wakeups against its incoming sources (bypass)
  assign src = wr_en ? wr_data : payload;

  always_comb begin
    logic [WIDTH_REG-1:0] dst_k;
    hit1  = 1'b0;
    hit2  = 1'b0;
    dst_k = '0;
    for (int k = 0; k < NWB; k++) begin
      dst_k = WIDTH_REG'(wb_slice(WB_FLAT_MAX'(wb_dst), k, WIDTH_REG));
      if (wb_val[k] && dst_k == src[RS1_LO +: WIDTH_REG]) hit1 = 1'b1;
      if (wb_val[k] && dst_k == src[RS2_LO +: WIDTH_REG]) hit2 = 1'b1;
    end
  end

  assign kill_hit = |(src[BRM_LO +: WIDTH_BRM] & br_kill);
  assign killed   = valid & kill_hit;
  assign req      = valid & p1 & p2 & ~|(payload[BRM_LO +: WIDTH_BRM] & br_kill);

  always_comb begin
    valid_next = valid;
    if (flush)         valid_next = 1'b0;
    else if (kill_hit) valid_next = 1'b0;
    else if (iss_en)   valid_next = 1'b0;
    else if (wr_en)    valid_next = 1'b1;
  end

  always_comb begin
    new_pay = src;
    new_pay[BRM_LO +: WIDTH_BRM] = src[BRM_LO +: WIDTH_BRM] & ~br_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      p1    <= 1'b0;
      p2    <= 1'b0;
    end else begin
      valid <= valid_next;
      p1    <= wr_en ? (wr_p1 | hit1) : (p1 | hit1);
      p2    <= wr_en ? (wr_p2 | hit2) : (p2 | hit2);
    end
  end

  always_ff @(posedge clk) begin
    payload <= new_pay;
  end

endmodule

// File: rtl/issue_queue.sv
// N-entry out-of-order issue queue: lowest-free-slot dispatch, age-matrix
// oldest-ready select, one issue per cycle through a valid/ready handshake.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int DEPTH     = 8,
  parameter int NWB       = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  issue_queue_if.slave bus
);

  localparam int WP        = pay_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM);
  localparam int WIDTH_CNT = $clog2(DEPTH + 1);
  localparam int BRM_LO    = off_brm(WIDTH_REG, WIDTH_TAG);

  logic [DEPTH-1:0]     valid, valid_next, req, killed, sel, wr_en, iss_en;
  logic [WP-1:0]        pay [DEPTH];
  logic [DEPTH-1:0]     age [DEPTH];
  logic                 dis_fire, iss_fire;
  logic [WP-1:0]        sel_pay, iss_data;
  logic [WIDTH_CNT-1:0] count, cnt_next;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    iq_slot #(
      .WIDTH_REG(WIDTH_REG),
      .WIDTH_TAG(WIDTH_TAG),
      .WIDTH_BRM(WIDTH_BRM),
      .NWB      (NWB)
    ) u_slot (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .flush     (bus.i_flush),
      .br_kill   (bus.i_br_kill),
      .br_clr    (bus.i_br_clr),
      .wb_val    (bus.i_wb_val),
      .wb_dst    (bus.i_wb_dst),
      .wr_en     (wr_en[g]),
      .wr_data   (bus.i_dis_data),
      .wr_p1     (bus.i_dis_p1),
      .wr_p2     (bus.i_dis_p2),
      .iss_en    (iss_en[g]),
      .valid     (valid[g]),
      .valid_next(valid_next[g]),
      .req       (req[g]),
      .killed    (killed[g]),
      .payload   (pay[g])
    );
  end

  // Full-ness comes from registered state only, so an issue cannot make room this cycle
  assign bus.o_dis_rdy = ~&valid;
  assign dis_fire      = bus.i_dis_val & ~&valid & ~bus.i_flush;

  always_comb begin
    logic found;
    wr_en = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !found) begin
        wr_en[i] = dis_fire;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    sel     = '0;
    sel_pay = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = req[i] & ~|(req & age[i]);
      if (sel[i]) sel_pay = sel_pay | pay[i];
    end
  end

  always_comb begin
    iss_data = sel_pay;
    iss_data[BRM_LO +: WIDTH_BRM] = sel_pay[BRM_LO +: WIDTH_BRM] & ~bus.i_br_clr;
  end

  assign bus.o_iss_val  = |req;
  assign bus.o_iss_data = iss_data;
  assign iss_fire       = (|req) & bus.i_iss_rdy;
  assign iss_en         = sel & {DEPTH{iss_fire}};

  // New entry is younger than every survivor; nobody is younger than it yet
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) age[i] <= valid & ~(iss_en | killed);
        else          age[i] <= age[i] & ~wr_en;
      end
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) cnt_next = cnt_next + WIDTH_CNT'(valid_next[i]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count <= '0;
    else          count <= cnt_next;
  end

  assign bus.o_count = count;

endmodule

// File: tb/tb_issue_queue.sv
// Scenario bench for issue_queue: issued payloads are checked in order against a scoreboard queue.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int WR     = 5;
  localparam int WT     = 5;
  localparam int WB     = 3;
  localparam int D      = 8;
  localparam int N      = 4;
  localparam int WP     = pay_width(WR, WT, WB);
  localparam int BRM_LO = off_brm(WR, WT);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  logic [WP-1:0] exp_q[$];

  issue_queue_if #(.WIDTH_REG(WR), .WIDTH_TAG(WT), .WIDTH_BRM(WB), .DEPTH(D), .NWB(N)) bus ();

  issue_queue #(.WIDTH_REG(WR), .WIDTH_TAG(WT), .WIDTH_BRM(WB), .DEPTH(D), .NWB(N)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WP-1:0] mk(input logic [6:0] uop, input logic [2:0] brm,
                                       input logic [4:0] tag, input logic [4:0] rd,
                                       input logic [4:0] rs2, input logic [4:0] rs1);
    return {uop, brm, tag, rd, rs2, rs1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_flush    = 1'b0;
    bus.i_dis_val  = 1'b0;
    bus.i_dis_data = '0;
    bus.i_dis_p1   = 1'b0;
    bus.i_dis_p2   = 1'b0;
    bus.i_wb_val   = '0;
    bus.i_wb_dst   = '0;
    bus.i_br_kill  = '0;
    bus.i_br_clr   = '0;
    bus.i_iss_rdy  = 1'b0;
  endtask

  task automatic dispatch(input logic [WP-1:0] data, input logic p1, input logic p2);
    bus.i_dis_val  = 1'b1;
    bus.i_dis_data = data;
    bus.i_dis_p1   = p1;
    bus.i_dis_p2   = p2;
  endtask

  // Every accepted issue must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [WP-1:0] e;
    if (rst_n && bus.o_iss_val && bus.i_iss_rdy) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_issue got=%h expected=none", bus.o_iss_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_iss_data !== e) begin
          mismatched++;
          $display("[TB] FAIL issue_payload got=%h expected=%h", bus.o_iss_data, e);
        end
      end
    end
  end

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #3;
    compared += 3;
    if (bus.o_dis_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_dis_rdy got=%b expected=1", bus.o_dis_rdy); end
    if (bus.o_iss_val !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_iss_val got=%b expected=0", bus.o_iss_val); end
    if (bus.o_count !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_count got=%0d expected=0", bus.o_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_issue();
    logic [WP-1:0] d;
    d = mk(7'h11, 3'b000, 5'd1, 5'd2, 5'd4, 5'd3);
    dispatch(d, 1'b1, 1'b1);
    exp_q.push_back(d);
    tick();
    bus.i_dis_val = 1'b0;
    bus.i_iss_rdy = 1'b1;
    @(negedge clk);
    compared += 2;
    if (bus.o_iss_val !== 1'b1) begin mismatched++; $display("[TB] FAIL single_iss_val got=%b expected=1", bus.o_iss_val); end
    if (bus.o_count !== 4'd1) begin mismatched++; $display("[TB] FAIL single_count got=%0d expected=1", bus.o_count); end
    tick();
    bus.i_iss_rdy = 1'b0;
    @(negedge clk);
    compared += 3;
    if (bus.o_iss_val !== 1'b0) begin mismatched++; $display("[TB] FAIL single_after_val got=%b expected=0", bus.o_iss_val); end
    if (bus.o_count !== 4'd0) begin mismatched++; $display("[TB] FAIL single_after_count got=%0d expected=0", bus.o_count); end
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL single_pending got=%0d expected=0", exp_q.size()); end
    tick();
  endtask

  task automatic test_wakeup_latency();
    logic [WP-1:0] d;
    d = mk(7'h22, 3'b000, 5'd2, 5'd6, 5'd6, 5'd5);
    dispatch(d, 1'b0, 1'b1);
    exp_q.push_back(d);
    tick();
    bus.i_dis_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (bus.o_iss_val !== 1'b0) begin mismatched++; $display("[TB] FAIL wake_idle%0d got=%b expected=0", i, bus.o_iss_val); end
      tick();
    end
    bus.i_wb_val = 4'b0100;
    bus.i_wb_dst = {5'd0, 5'd5, 5'd0, 5'd0};
    @(negedge clk);
    compared++;
    if (bus.o_iss_val !== 1'b0) begin mismatched++; $display("[TB] FAIL wake_same_cycle got=%b expected=0", bus.o_iss_val); end
    tick();
    bus.i_wb_val  = '0;
    bus.i_wb_dst  = '0;
    bus.i_iss_rdy = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.o_iss_val !== 1'b1) begin mismatched++; $display("[TB] FAIL wake_next_cycle got=%b expected=1", bus.o_iss_val); end
    tick();
    bus.i_iss_rdy = 1'b0;
    @(negedge clk);
    compared += 2;
    if (bus.o_count !== 4'd0) begin mismatched++; $display("[TB] FAIL wake_count got=%0d expected=0", bus.o_count); end
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL wake_pending got=%0d expected=0", exp_q.size()); end
    tick();
  endtask

  task automatic test_age_order();
    logic [WP-1:0] a, b, c, dd;
    a  = mk(7'h31, 3'b100, 5'd3, 5'd8,  5'd1, 5'd7);
    b  = mk(7'h32, 3'b000, 5'd4, 5'd9,  5'd1, 5'd7);
    c  = mk(7'h33, 3'b000, 5'd5, 5'd10, 5'd1, 5'd7);
    dd = mk(7'h34, 3'b000, 5'd6, 5'd11, 5'd1, 5'd7);
    dispatch(a, 1'b0, 1'b1);
    tick();
    dispatch(b, 1'b0, 1'b1);
    exp_q.push_back(b);
    tick();
    dispatch(c, 1'b0, 1'b1);
    exp_q.push_back(c);
    tick();
    bus.i_dis_val = 1'b0;
    bus.i_br_kill = 3'b100;
    tick();
    bus.i_br_kill = '0;
    @(negedge clk);
    compared++;
    if (bus.o_count !== 4'd2) begin mismatched++; $display("[TB] FAIL age_after_kill got=%0d expected=2", bus.o_count); end
    dispatch(dd, 1'b0, 1'b1);
    exp_q.push_back(dd);
    tick();
    bus.i_dis_val = 1'b0;
    bus.i_wb_val  = 4'b0001;
    bus.i_wb_dst  = {5'd0, 5'd0, 5'd0, 5'd7};
    tick();
    bus.i_wb_val  = '0;
    bus.i_wb_dst  = '0;
    bus.i_iss_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.i_iss_rdy = 1'b0;
    @(negedge clk);
    compared += 2;
    if (bus.o_count !== 4'd0) begin mismatched++; $display("[TB] FAIL age_count got=%0d expected=0", bus.o_count); end
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL age_pending got=%0d expected=0", exp_q.size()); end
    tick();
  endtask

  task automatic test_branch();
    logic [WP-1:0] x, y;
    logic [2:0]    m;
    x = mk(7'h41, 3'b010, 5'd7, 5'd12, 5'd2, 5'd1);
    y = mk(7'h42, 3'b001, 5'd8, 5'd13, 5'd2, 5'd1);
    dispatch(x, 1'b1, 1'b1);
    tick();
    dispatch(y, 1'b1, 1'b1);
    exp_q.push_back(mk(7'h42, 3'b000, 5'd8, 5'd13, 5'd2, 5'd1));
    tick();
    bus.i_dis_val = 1'b0;
    @(negedge clk);
    compared += 2;
    if (bus.o_count !== 4'd2) begin mismatched++; $display("[TB] FAIL br_count_before got=%0d expected=2", bus.o_count); end
    if (bus.o_iss_val !== 1'b1) begin mismatched++; $display("[TB] FAIL br_val_before got=%b expected=1", bus.o_iss_val); end
    bus.i_br_kill = 3'b010;
    tick();
    bus.i_br_kill = '0;
    @(negedge clk);
    compared++;
    if (bus.o_count !== 4'd1) begin mismatched++; $display("[TB] FAIL br_kill_count got=%0d expected=1", bus.o_count); end
    bus.i_br_clr = 3'b001;
    tick();
    bus.i_br_clr  = '0;
    bus.i_iss_rdy = 1'b1;
    @(negedge clk);
    m = bus.o_iss_data[BRM_LO +: 3];
    compared++;
    if (m !== 3'b000) begin mismatched++; $display("[TB] FAIL br_clr_mask got=%b expected=000", m); end
    tick();
    bus.i_iss_rdy = 1'b0;
    @(negedge clk);
    compared += 2;
    if (bus.o_count !== 4'd0) begin mismatched++; $display("[TB] FAIL br_count_after got=%0d expected=0", bus.o_count); end
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL br_pending got=%0d expected=0", exp_q.size()); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) begin
      dispatch(mk(7'(80 + i), 3'd0, 5'(i), 5'(i), 5'd2, 5'(10 + i)), 1'b0, 1'b1);
      if (i == 3) exp_q.push_back(mk(7'(80 + i), 3'd0, 5'(i), 5'(i), 5'd2, 5'(10 + i)));
      tick();
    end
    bus.i_dis_val = 1'b0;
    @(negedge clk);
    compared += 2;
    if (bus.o_dis_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL full_dis_rdy got=%b expected=0", bus.o_dis_rdy); end
    if (bus.o_count !== 4'd8) begin mismatched++; $display("[TB] FAIL full_count got=%0d expected=8", bus.o_count); end
    dispatch(mk(7'h7f, 3'd0, 5'd9, 5'd9, 5'd2, 5'd20), 1'b1, 1'b1);
    tick();
    bus.i_dis_val = 1'b0;
    @(negedge clk);
    compared += 2;
    if (bus.o_count !== 4'd8) begin mismatched++; $display("[TB] FAIL full_ninth_count got=%0d expected=8", bus.o_count); end
    if (bus.o_iss_val !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ninth_val got=%b expected=0", bus.o_iss_val); end
    bus.i_wb_val = 4'b0001;
    bus.i_wb_dst = {5'd0, 5'd0, 5'd0, 5'd13};
    tick();
    bus.i_wb_val  = '0;
    bus.i_wb_dst  = '0;
    bus.i_iss_rdy = 1'b1;
    tick();
    bus.i_iss_rdy = 1'b0;
    @(negedge clk);
    compared += 3;
    if (bus.o_dis_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL full_reopen_rdy got=%b expected=1", bus.o_dis_rdy); end
    if (bus.o_count !== 4'd7) begin mismatched++; $display("[TB] FAIL full_reopen_count got=%0d expected=7", bus.o_count); end
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL full_pending got=%0d expected=0", exp_q.size()); end
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
  endtask

  task automatic test_bypass_flush();
    logic [WP-1:0] d;
    d = mk(7'h61, 3'b000, 5'd10, 5'd14, 5'd9, 5'd8);
    dispatch(d, 1'b1, 1'b0);
    bus.i_wb_val = 4'b0001;
    bus.i_wb_dst = {5'd0, 5'd0, 5'd0, 5'd9};
    exp_q.push_back(d);
    tick();
    bus.i_dis_val = 1'b0;
    bus.i_wb_val  = '0;
    bus.i_wb_dst  = '0;
    bus.i_iss_rdy = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.o_iss_val !== 1'b1) begin mismatched++; $display("[TB] FAIL bypass_iss_val got=%b expected=1", bus.o_iss_val); end
    tick();
    bus.i_iss_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dispatch(mk(7'(100 + i), 3'd0, 5'(20 + i), 5'(20 + i), 5'd2, 5'(21 + i)), 1'b0, 1'b1);
      tick();
    end
    bus.i_dis_val = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.o_count !== 4'd3) begin mismatched++; $display("[TB] FAIL flush_before got=%0d expected=3", bus.o_count); end
    bus.i_flush = 1'b1;
    dispatch(mk(7'h70, 3'd0, 5'd30, 5'd30, 5'd2, 5'd2), 1'b1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    compared += 4;
    if (bus.o_count !== 4'd0) begin mismatched++; $display("[TB] FAIL flush_count got=%0d expected=0", bus.o_count); end
    if (bus.o_iss_val !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_iss_val got=%b expected=0", bus.o_iss_val); end
    if (bus.o_dis_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_dis_rdy got=%b expected=1", bus.o_dis_rdy); end
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL flush_pending got=%0d expected=0", exp_q.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_wakeup_latency();
    test_age_order();
    test_branch();
    test_full();
    test_bypass_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
